// File: rtl/register_file_8x16_pkg.sv
// rtl/register_file_8x16_pkg.sv - shared encodings for the 8x16 register file
package register_file_8x16_pkg;

    localparam logic [1:0] FS_DEC  = 2'b00;
    localparam logic [1:0] FS_INC  = 2'b01;
    localparam logic [1:0] FS_LOAD = 2'b10;
    localparam logic [1:0] FS_CLR  = 2'b11;

    localparam logic [2:0] SEL_R1 = 3'b000;
    localparam logic [2:0] SEL_R2 = 3'b001;
    localparam logic [2:0] SEL_R3 = 3'b010;
    localparam logic [2:0] SEL_R4 = 3'b011;
    localparam logic [2:0] SEL_S1 = 3'b100;
    localparam logic [2:0] SEL_S2 = 3'b101;
    localparam logic [2:0] SEL_S3 = 3'b110;
    localparam logic [2:0] SEL_S4 = 3'b111;

    localparam int EN_BIT_1 = 0;
    localparam int EN_BIT_2 = 1;
    localparam int EN_BIT_3 = 2;
    localparam int EN_BIT_4 = 3;

    localparam int NUM_REGS = 8;

endpackage

// File: rtl/register_file_8x16_reg_cell_sr.sv
// rtl/register_file_8x16_reg_cell_sr.sv - one register with dec/inc/load/clear and sync reset
module reg_cell_sr
    import register_file_8x16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             E,
    input  logic [1:0]       FunSel,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (E) begin
            case (FunSel)
                FS_DEC:  q_d = q_q - WIDTH'(1);
                FS_INC:  q_d = q_q + WIDTH'(1);
                FS_LOAD: q_d = I;
                FS_CLR:  q_d = '0;
                // an unknown select holds rather than corrupting the register
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/register_file_8x16.sv
// rtl/register_file_8x16.sv - R1-R4 / S1-S4 register file with two combinational read ports
module register_file_8x16
    import register_file_8x16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic [1:0]       FunSel,
    input  logic [3:0]       RegSel,
    input  logic [3:0]       ScrSel,
    input  logic [2:0]       OutASel,
    input  logic [2:0]       OutBSel,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB
);

    // enable index matches the read-select encoding: 0-3 general, 4-7 scratch
    logic [NUM_REGS-1:0] en;
    logic [WIDTH-1:0]    regs [NUM_REGS];

    assign en = {ScrSel, RegSel};

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
        reg_cell_sr #(
            .WIDTH (WIDTH)
        ) u_cell (
            .Clock  (Clock),
            .Reset  (Reset),
            .E      (en[g]),
            .FunSel (FunSel),
            .I      (I),
            .Q      (regs[g])
        );
    end

    always_comb begin
        OutA = regs[OutASel];
        OutB = regs[OutBSel];
    end

endmodule

// File: tb/tb_register_file_8x16.sv
// tb/tb_register_file_8x16.sv - directed self-checking bench for register_file_8x16
module tb_register_file_8x16;

    logic        Clock;
    logic        Reset;
    logic [15:0] I;
    logic [1:0]  FunSel;
    logic [3:0]  RegSel;
    logic [3:0]  ScrSel;
    logic [2:0]  OutASel;
    logic [2:0]  OutBSel;
    logic [15:0] OutA;
    logic [15:0] OutB;

    int errors = 0;
    int checks = 0;

    register_file_8x16 #(.WIDTH(16)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .I       (I),
        .FunSel  (FunSel),
        .RegSel  (RegSel),
        .ScrSel  (ScrSel),
        .OutASel (OutASel),
        .OutBSel (OutBSel),
        .OutA    (OutA),
        .OutB    (OutB)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [2:0] sel, input logic [15:0] exp);
        OutASel = sel;
        OutBSel = 3'd7 - sel;
        #1;
        check($sformatf("%s_A%0d", tag, sel), OutA, exp);
        OutBSel = sel;
        #1;
        check($sformatf("%s_B%0d", tag, sel), OutB, exp);
    endtask

    logic [15:0] exp_regs [8];

    initial begin
        Reset   = 1'b0;
        I       = 16'h0000;
        FunSel  = 2'b10;
        RegSel  = 4'h0;
        ScrSel  = 4'h0;
        OutASel = 3'd0;
        OutBSel = 3'd0;

        // random preload of every register, then one reset edge
        tick();
        for (int k = 0; k < 8; k++) begin
            I      = 16'($urandom_range(1, 16'hFFFF));
            FunSel = 2'b10;
            RegSel = (k < 4) ? 4'(1 << k) : 4'h0;
            ScrSel = (k >= 4) ? 4'(1 << (k - 4)) : 4'h0;
            tick();
        end
        Reset  = 1'b1;
        FunSel = 2'b01;
        RegSel = 4'hF;
        ScrSel = 4'hF;
        tick();
        Reset  = 1'b0;
        RegSel = 4'h0;
        ScrSel = 4'h0;
        for (int s = 0; s < 8; s++) check_reg("reset", 3'(s), 16'h0000);

        // loads into R1 and S4
        FunSel = 2'b10;
        I      = 16'h1234;
        RegSel = 4'b0001;
        tick();
        I      = 16'hABCD;
        RegSel = 4'b0000;
        ScrSel = 4'b1000;
        tick();
        ScrSel = 4'b0000;
        OutASel = 3'b000;
        OutBSel = 3'b111;
        #1;
        check("load_r1", OutA, 16'h1234);
        check("load_s4", OutB, 16'hABCD);
        for (int s = 1; s < 7; s++) check_reg("load_other", 3'(s), 16'h0000);

        // R2 wrap in both directions
        FunSel = 2'b11;
        RegSel = 4'b0010;
        tick();
        FunSel = 2'b00;
        tick();
        RegSel = 4'b0000;
        check_reg("dec_wrap", 3'b001, 16'hFFFF);
        FunSel = 2'b01;
        RegSel = 4'b0010;
        tick();
        RegSel = 4'b0000;
        check_reg("inc_wrap", 3'b001, 16'h0000);

        // multi-enable increment: R1=5, S2=9, R3=3 (held)
        FunSel = 2'b10;
        I      = 16'h0005;
        RegSel = 4'b0001;
        tick();
        I      = 16'h0009;
        RegSel = 4'b0000;
        ScrSel = 4'b0010;
        tick();
        I      = 16'h0003;
        RegSel = 4'b0100;
        ScrSel = 4'b0000;
        tick();
        FunSel = 2'b01;
        RegSel = 4'b0001;
        ScrSel = 4'b0010;
        tick();
        RegSel = 4'b0000;
        ScrSel = 4'b0000;
        check_reg("multi_r1", 3'b000, 16'h0006);
        check_reg("multi_s2", 3'b101, 16'h000A);
        check_reg("multi_r3", 3'b010, 16'h0003);
        check_reg("multi_s4", 3'b111, 16'hABCD);

        // decrement of non-zero on R3 while others hold
        FunSel = 2'b00;
        RegSel = 4'b0100;
        tick();
        RegSel = 4'b0000;
        check_reg("dec_r3", 3'b010, 16'h0002);

        // no enables: state held whatever FunSel and I are
        FunSel = 2'b11;
        I      = 16'h5555;
        tick();
        check_reg("hold_r1", 3'b000, 16'h0006);

        // read-during-write on R2
        FunSel = 2'b10;
        I      = 16'h0007;
        RegSel = 4'b0010;
        tick();
        I       = 16'h0042;
        OutASel = 3'b001;
        OutBSel = 3'b001;
        #1;
        check("rdw_before_A", OutA, 16'h0007);
        check("rdw_before_B", OutB, 16'h0007);
        tick();
        RegSel = 4'b0000;
        check("rdw_after_A", OutA, 16'h0042);
        check("rdw_after_B", OutB, 16'h0042);

        // reset wins over a simultaneous load on every register
        Reset  = 1'b1;
        FunSel = 2'b10;
        I      = 16'hFFFF;
        RegSel = 4'hF;
        ScrSel = 4'hF;
        tick();
        Reset  = 1'b0;
        RegSel = 4'h0;
        ScrSel = 4'h0;
        for (int s = 0; s < 8; s++) exp_regs[s] = 16'h0000;
        for (int s = 0; s < 8; s++) check_reg("rst_load", 3'(s), exp_regs[s]);
        tick();
        for (int s = 0; s < 8; s++) check_reg("rst_after", 3'(s), exp_regs[s]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_file_8x16.md
Name: register_file_8x16

Overview:
- Register file directly upstream of the ALU. It holds 4 general-purpose registers (R1–R4) and 4 scratch registers (S1–S4), each WIDTH bits wide.
- All registers share one function select. Per-register enables choose which registers act on a given edge.
- Two independent combinational read ports (OutA, OutB) supply the ALU A and B operands.
- The same input bus I loads any enabled register. It is normally driven by the ALU output or a memory/IR mux.

Parameters:
WIDTH, 16, data width of every register and of I/OutA/OutB

Ports:
Clock  input  1  system clock; all state changes on the rising edge
Reset  input  1  synchronous, active-high reset; clears all 8 registers
I  input  WIDTH  load data bus
FunSel  input  2  00 decrement, 01 increment, 10 load I, 11 clear
RegSel  input  4  active-high enables; bit0=R1, bit1=R2, bit2=R3, bit3=R4
ScrSel  input  4  active-high enables; bit0=S1, bit1=S2, bit2=S3, bit3=S4
OutASel  input  3  read select A: 000–011 = R1–R4, 100–111 = S1–S4
OutBSel  input  3  read select B: same encoding as OutASel
OutA  output  WIDTH  contents of register selected by OutASel
OutB  output  WIDTH  contents of register selected by OutBSel

Behaviour:
- Reset:
  - Sampled on the rising edge of Clock. Reset=1 forces all 8 registers to 0 on that edge.
  - Reset overrides RegSel, ScrSel and FunSel.
  - OutA/OutB therefore read 0 from the edge after reset is applied.
  - There is no asynchronous path. Before the first reset edge, register contents are undefined (X in simulation).
- Write, Reset=0, per rising edge:
  - Each register whose enable bit is 1 applies FunSel:
    - 00: Q <= Q − 1 (mod 2^WIDTH)
    - 01: Q <= Q + 1 (mod 2^WIDTH)
    - 10: Q <= I
    - 11: Q <= 0
  - A register whose enable bit is 0 holds its value.
- Multiple enables: any combination of the 8 enable bits may be 1 in the same cycle. Every enabled register performs the same FunSel operation on its own current value. For example, inc with R1 and S3 enabled increments each independently.
- Wrap-around:
  - Decrement of 0 gives all-ones (16'hFFFF at WIDTH=16). No flag is produced.
  - Increment of all-ones gives 0. No flag is produced.
- Read ports:
  - Purely combinational mux from current register state, so there is zero latency to select changes.
  - OutA and OutB may select the same register.
- Read-during-write:
  - In the cycle of a write, OutA/OutB show the pre-edge value.
  - The new value appears after the rising edge. There is no write-through bypass.
- Latency: a write issued in cycle n is visible on the read ports in cycle n+1.
- No enables set: the state is unchanged whatever FunSel and I are.
- Reset mid-operation: Reset=1 on an edge where a load or increment is also requested gives 0 in all registers. The requested operation is discarded.
- X-safety: an unknown FunSel with an enable set must not occur in normal operation. The design holds the register's value (default branch).

Decomposition:
- Shared package constants:
  - FunSel encodings: FS_DEC=2'b00, FS_INC=2'b01, FS_LOAD=2'b10, FS_CLR=2'b11
  - Read-select encodings: SEL_R1..SEL_R4 = 3'b000–3'b011, SEL_S1..SEL_S4 = 3'b100–3'b111
  - The 4-bit enable bit positions
- One sub-module: reg_cell_sr, a WIDTH-bit register with synchronous active-high Reset, E, FunSel and I, implementing the write rules above. It is instantiated 8 times.
- The top level holds the 8 instances plus two 8:1 read muxes.

Test Plan:
- Reset=1 for one edge after random preloads → all 8 selects on OutA and OutB read 16'h0000.
- FunSel=10, I=16'h1234, RegSel=0001, then I=16'hABCD, ScrSel=1000 → OutASel=000 reads 1234, OutBSel=111 reads ABCD, all others still 0.
- R2 cleared, FunSel=00 with RegSel=0010 for one edge → R2 = 16'hFFFF. Then FunSel=01 for one edge → R2 = 16'h0000 (both wraps).
- Multi-enable: R1=5, S2=9, FunSel=01, RegSel=0001, ScrSel=0010 for one edge → R1=6, S2=10, R3 unchanged.
- Read-during-write: OutASel=001 with R2=7, load I=16'h0042 into R2 → OutA=7 before the edge and 42 after. OutBSel=001 at the same time also reads 42 after the edge.
- Reset with FunSel=10, I=16'hFFFF and all enables set on the same edge → all registers 0. The next edge with Reset=0 and no enables → still 0.
